// File: rtl/dma_line_mover.sv
// Line-copy DMA engine driving the mem_cntrl request interface: reads a line into a
// local buffer and writes it back out, or writes a fixed pattern in fill mode.
module dma_line_mover #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 64,
  parameter int          LINE_WORDS = 16,
  parameter int          LEN_W      = 16,
  parameter logic [63:0] CV_VALUE   = 64'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  num_lines,
  input  logic [DATA_W-1:0] fill_pattern,
  input  logic              tx_done,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] common_data_bus_in,
  output logic [1:0]        op,
  output logic [ADDR_W-1:0] io_address,
  output logic [DATA_W-1:0] common_data_bus_out,
  output logic [63:0]       cv_value,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  lines_done,
  output logic              err
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0]  STRIDE = ADDR_W'(LINE_WORDS * DATA_W / 8);
  localparam logic [IDX_W+1:0]   LW_CNT = (IDX_W + 2)'(LINE_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR_DATA, S_DONE} state_t;
  state_t state;

  logic              mode_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  num_q;
  logic [DATA_W-1:0] fill_q;
  logic [IDX_W-1:0]  rd_cnt;
  logic [IDX_W-1:0]  wr_idx;
  // rd_cnt wraps with the buffer; rd_total saturates so an overrun still flags err.
  logic [IDX_W+1:0]  rd_total;
  logic [IDX_W+1:0]  rd_final;
  logic [LEN_W-1:0]  lines_next;
  logic [DATA_W-1:0] buffer [LINE_WORDS];

  assign rd_final   = rd_total + (IDX_W + 2)'(rd_valid);
  assign lines_next = lines_done + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      num_q      <= '0;
      fill_q     <= '0;
      rd_cnt     <= '0;
      wr_idx     <= '0;
      rd_total   <= '0;
      lines_done <= '0;
      err        <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) buffer[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            src_q      <= src_base;
            dst_q      <= dst_base;
            num_q      <= num_lines;
            fill_q     <= fill_pattern;
            rd_cnt     <= '0;
            wr_idx     <= '0;
            rd_total   <= '0;
            lines_done <= '0;
            err        <= 1'b0;
            if (num_lines == '0) state <= S_DONE;
            else if (mode)       state <= S_WR_SETUP;
            else                 state <= S_RD;
          end
        end
        S_RD: begin
          if (rd_valid) begin
            buffer[rd_cnt] <= common_data_bus_in;
            rd_cnt         <= rd_cnt + 1'b1;
            if (rd_total <= LW_CNT) rd_total <= rd_total + 1'b1;
          end
          if (tx_done) begin
            if (rd_final != LW_CNT) err <= 1'b1;
            state <= S_WR_SETUP;
          end
        end
        S_WR_SETUP: state <= S_WR_DATA;
        S_WR_DATA: begin
          wr_idx <= wr_idx + 1'b1;
          if (tx_done) begin
            lines_done <= lines_next;
            rd_cnt     <= '0;
            wr_idx     <= '0;
            rd_total   <= '0;
            src_q      <= src_q + STRIDE;
            dst_q      <= dst_q + STRIDE;
            if (lines_next == num_q) state <= S_DONE;
            else if (mode_q)         state <= S_WR_SETUP;
            else                     state <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    op                  = 2'b00;
    io_address          = '0;
    common_data_bus_out = '0;
    case (state)
      S_RD: begin
        op         = 2'b01;
        io_address = src_q;
      end
      S_WR_SETUP: begin
        op                  = 2'b11;
        io_address          = dst_q;
        common_data_bus_out = mode_q ? fill_q : buffer[0];
      end
      S_WR_DATA: begin
        op                  = 2'b11;
        io_address          = dst_q;
        common_data_bus_out = mode_q ? fill_q : buffer[wr_idx];
      end
      default: ;
    endcase
  end

  assign busy     = (state == S_RD) || (state == S_WR_SETUP) || (state == S_WR_DATA);
  assign done     = (state == S_DONE);
  assign cv_value = CV_VALUE;
endmodule
